// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR constants and serial receiver state type
package fir_pkg;

  localparam int FIR_DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SHIFT = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered pointers and occupancy output
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW:0]      o_fill
);

  // Pointers carry one extra bit so full and empty stay distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign o_fill  = wr_ptr - rd_ptr;
  assign o_empty = (o_fill == '0);
  assign o_full  = (o_fill == (AW+1)'(DEPTH));
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_data  = o_empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/fir_serial_rx.sv
// rtl/fir_serial_rx.sv - LSB-first serial word receiver feeding a parallel FIFO
// Optional word counter and stall flag under FIR_SERIAL_RX_COUNT_EN.
module fir_serial_rx
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  localparam int FILL_W = $clog2(FIFO_DEPTH) + 1,
  localparam int CNT_W  = $clog2(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_din,
  input  logic                  i_din_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_word_valid,
  input  logic                  i_word_ready,
`ifdef FIR_SERIAL_RX_COUNT_EN
  output logic [15:0]           o_word_count,
  output logic                  o_stall,
`endif
  output logic [FILL_W-1:0]     o_fill
);

  rx_state_t             state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] word_in;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  last_bit;
  logic                  start;

  // Only this FSM pushes, so a not-full check at IDLE holds for the whole word.
  assign start    = i_en && i_din_valid && !fifo_full;
  assign last_bit = (state == SHIFT) && (cnt == CNT_W'(DATA_WIDTH - 1));
  assign o_ready  = (state == GRANT) || (state == SHIFT);

  always_comb begin
    word_in      = shreg;
    word_in[cnt] = i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= GRANT;
        GRANT: begin
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          shreg[cnt] <= i_din;
          cnt        <= cnt + 1'b1;
          if (last_bit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (last_bit),
    .i_pop   (i_word_ready),
    .i_data  (word_in),
    .o_data  (o_word),
    .o_empty (fifo_empty),
    .o_full  (fifo_full),
    .o_fill  (o_fill)
  );

  assign o_word_valid = !fifo_empty;

`ifdef FIR_SERIAL_RX_COUNT_EN
  logic [15:0] word_count;
  logic        stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_count <= '0;
      stall      <= 1'b0;
    end else begin
      if (last_bit) word_count <= word_count + 1'b1;
      stall <= (state == IDLE) && i_din_valid && fifo_full;
    end
  end

  assign o_word_count = word_count;
  assign o_stall      = stall;
`endif

endmodule

// File: tb/tb_fir_serial_rx.sv
// tb/tb_fir_serial_rx.sv - directed self-checking bench for fir_serial_rx
module tb_fir_serial_rx;

  logic        tb_clk = 1'b0;
  logic        i_rst_n;
  logic        i_en;
  logic        i_din;
  logic        i_din_valid;
  logic        o_ready;
  logic [23:0] o_word;
  logic        o_word_valid;
  logic        i_word_ready;
  logic [2:0]  o_fill;
`ifdef FIR_SERIAL_RX_COUNT_EN
  logic [15:0] o_word_count;
  logic        o_stall;
`endif

  int vectors = 0;
  int miscompares = 0;
  int last_ready_cycles;
  int last_wait;

  always #5 tb_clk = ~tb_clk;

  fir_serial_rx dut (
    .i_clk        (tb_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_en),
    .i_din        (i_din),
    .i_din_valid  (i_din_valid),
    .o_ready      (o_ready),
    .o_word       (o_word),
    .o_word_valid (o_word_valid),
    .i_word_ready (i_word_ready),
`ifdef FIR_SERIAL_RX_COUNT_EN
    .o_word_count (o_word_count),
    .o_stall      (o_stall),
`endif
    .o_fill       (o_fill)
  );

  // Behaves like the upstream filter: raise valid, wait for grant, shift LSB first.
  task automatic send_word(input logic [23:0] w, input bit drop_en, input bit pop_last);
    int guard;
    int rc;
    guard = 0;
    i_din_valid = 1'b1;
    while (!o_ready && guard < 200) begin
      @(negedge tb_clk);
      guard++;
    end
    last_wait = guard;
    vectors++;
    if (o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL grant_timeout word=%h o_ready=%b required 1", w, o_ready);
      i_din_valid = 1'b0;
      return;
    end
    rc = 1;
    i_din_valid = 1'b0;
    for (int n = 0; n < 24; n++) begin
      @(negedge tb_clk);
      i_din = w[n];
      if (o_ready) rc++;
      if (drop_en && n == 5) i_en = 1'b0;
      if (pop_last && n == 23) i_word_ready = 1'b1;
    end
    @(negedge tb_clk);
    i_din = 1'b0;
    if (pop_last) i_word_ready = 1'b0;
    if (drop_en) i_en = 1'b1;
    last_ready_cycles = rc;
  endtask

  task automatic pop_check(input logic [23:0] exp, input string name);
    vectors++;
    if (o_word_valid !== 1'b1 || o_word !== exp) begin
      miscompares++;
      $display("FAIL %s o_word=%h valid=%b required %h valid=1", name, o_word, o_word_valid, exp);
    end
    i_word_ready = 1'b1;
    @(negedge tb_clk);
    i_word_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_en = 1'b1; i_din = 1'b0; i_din_valid = 1'b0; i_word_ready = 1'b0;
    repeat (3) @(negedge tb_clk);
    vectors++;
    if (o_ready !== 1'b0 || o_word_valid !== 1'b0 || o_word !== 24'h0 || o_fill !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_state ready=%b valid=%b word=%h fill=%0d required 0/0/0/0",
               o_ready, o_word_valid, o_word, o_fill);
    end
    i_rst_n = 1'b1;
    @(negedge tb_clk);
  endtask

  task automatic test_single();
    send_word(24'h000001, 1'b0, 1'b0);
    vectors++;
    if (last_ready_cycles != 25) begin
      miscompares++;
      $display("FAIL ready_width cycles=%0d required 25", last_ready_cycles);
    end
    vectors++;
    if (o_ready !== 1'b0 || o_word_valid !== 1'b1 || o_fill !== 3'd1) begin
      miscompares++;
      $display("FAIL single_after_e25 ready=%b valid=%b fill=%0d required 0/1/1",
               o_ready, o_word_valid, o_fill);
    end
    pop_check(24'h000001, "single_word");
    vectors++;
    if (o_word_valid !== 1'b0 || o_fill !== 3'd0) begin
      miscompares++;
      $display("FAIL single_drain valid=%b fill=%0d required 0/0", o_word_valid, o_fill);
    end
  endtask

  task automatic test_fullscale();
    send_word(24'h800000, 1'b0, 1'b0);
    send_word(24'h7FFFFF, 1'b0, 1'b0);
    vectors++;
    if (o_fill !== 3'd2) begin
      miscompares++;
      $display("FAIL fullscale_fill fill=%0d required 2", o_fill);
    end
    pop_check(24'h800000, "neg_full_scale");
    pop_check(24'h7FFFFF, "pos_full_scale");
  endtask

  task automatic test_backpressure();
    logic [23:0] w [5];
    bit seen;
    w[0] = 24'hABCDEF; w[1] = 24'h000F00; w[2] = 24'hFEDCBA; w[3] = 24'h5A5A5A; w[4] = 24'h13579B;
    i_word_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_word(w[k], 1'b0, 1'b0);
    vectors++;
    if (o_fill !== 3'd4) begin
      miscompares++;
      $display("FAIL bp_fill fill=%0d required 4", o_fill);
    end
    i_din_valid = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge tb_clk);
      if (o_ready) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_no_grant o_ready_seen=%b required 0", seen);
    end
    pop_check(w[0], "bp_pop0");
    send_word(w[4], 1'b0, 1'b0);
    vectors++;
    if (last_wait > 2) begin
      miscompares++;
      $display("FAIL bp_regrant wait=%0d required <=2", last_wait);
    end
    vectors++;
    if (o_fill !== 3'd4) begin
      miscompares++;
      $display("FAIL bp_refill fill=%0d required 4", o_fill);
    end
    for (int k = 1; k < 5; k++) pop_check(w[k], "bp_order");
    i_word_ready = 1'b1;
    @(negedge tb_clk);
    i_word_ready = 1'b0;
    vectors++;
    if (o_fill !== 3'd0 || o_word !== 24'h0) begin
      miscompares++;
      $display("FAIL pop_empty fill=%0d word=%h required 0/000000", o_fill, o_word);
    end
  endtask

  task automatic test_back_to_back();
    send_word(24'hC0FFEE, 1'b0, 1'b0);
    send_word(24'h0BEEF1, 1'b0, 1'b1);
    vectors++;
    if (o_fill !== 3'd1 || o_word !== 24'h0BEEF1) begin
      miscompares++;
      $display("FAIL push_pop_same fill=%0d word=%h required 1/0beef1", o_fill, o_word);
    end
    pop_check(24'h0BEEF1, "push_pop_tail");
  endtask

  task automatic test_reset_mid();
    logic [23:0] part;
    int guard;
    part = 24'hA5A5A5;
    send_word(24'h0F0F0F, 1'b0, 1'b0);
    i_din_valid = 1'b1;
    guard = 0;
    while (!o_ready && guard < 200) begin
      @(negedge tb_clk);
      guard++;
    end
    i_din_valid = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      @(negedge tb_clk);
      i_din = part[n];
    end
    @(negedge tb_clk);
    i_rst_n = 1'b0;
    #1;
    vectors++;
    if (o_ready !== 1'b0 || o_fill !== 3'd0 || o_word_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid ready=%b fill=%0d valid=%b required 0/0/0", o_ready, o_fill, o_word_valid);
    end
    @(negedge tb_clk);
    i_din = 1'b0;
    i_rst_n = 1'b1;
    @(negedge tb_clk);
    send_word(24'h123456, 1'b0, 1'b0);
    pop_check(24'h123456, "after_reset_word");
  endtask

  task automatic test_enable();
    bit seen;
    i_en = 1'b0;
    i_din_valid = 1'b1;
    seen = 1'b0;
    repeat (50) begin
      @(negedge tb_clk);
      if (o_ready) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL en_gating o_ready_seen=%b required 0", seen);
    end
    i_en = 1'b1;
    send_word(24'h3C3C3C, 1'b1, 1'b0);
    pop_check(24'h3C3C3C, "en_drop_in_shift");
  endtask

`ifdef FIR_SERIAL_RX_COUNT_EN
  task automatic test_count();
    test_reset();
    for (int k = 0; k < 3; k++) send_word(24'h010101 * (k + 1), 1'b0, 1'b0);
    vectors++;
    if (o_word_count !== 16'd3) begin
      miscompares++;
      $display("FAIL word_count got=%0d required 3", o_word_count);
    end
    send_word(24'h444444, 1'b0, 1'b0);
    i_din_valid = 1'b1;
    repeat (3) @(negedge tb_clk);
    vectors++;
    if (o_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_high got=%b required 1", o_stall);
    end
    i_din_valid = 1'b0;
    repeat (2) @(negedge tb_clk);
    vectors++;
    if (o_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_low got=%b required 0", o_stall);
    end
    for (int k = 0; k < 4; k++) pop_check(24'h010101 * (k + 1), "count_drain");
    force dut.word_count = 16'hFFFF;
    @(negedge tb_clk);
    release dut.word_count;
    send_word(24'h777777, 1'b0, 1'b0);
    vectors++;
    if (o_word_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL count_wrap got=%h required 0000", o_word_count);
    end
    pop_check(24'h777777, "count_wrap_word");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fullscale();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_enable();
`ifdef FIR_SERIAL_RX_COUNT_EN
    test_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
